pc_fetch_controller: RTL and testbench
======================================

# pc_fetch_controller

Sequencing controller for the program counter and front-end pipeline registers of the RV32IM pipeline. Each cycle it selects the next PC (sequential, branch/jump redirect, boot vector) and drives the PC hold line. It also drives the IF/ID and ID/EX flush/hold controls. It merges instruction/data memory busywait, load-use stalls and control-flow redirects, and latches a redirect that arrives while memory is busy so it is never lost.

## Interface
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset
- TRAP_VECTOR, 32'h0000_0100, redirect address for misaligned targets (used only with trap feature)
- CLK  in  1  system clock, all state updates on posedge
- RESET  in  1  synchronous, active-high reset
- pc  in  32  current PC register value
- inst_busywait  in  1  instruction memory busy
- data_busywait  in  1  data memory busy
- load_use_stall  in  1  hazard unit request: hold IF/ID, bubble ID/EX
- redirect_valid  in  1  resolved taken branch or jump in EX
- redirect_target  in  32  target address of redirect
- next_pc  out  32  value presented to PC write port
- pc_hold  out  1  1 = PC must not update (drives PC busyWait)
- if_id_hold  out  1  freeze IF/ID register
- if_id_flush  out  1  clear IF/ID to NOP
- id_ex_flush  out  1  insert bubble into ID/EX
- stall_count  out  16  saturating count of cycles with pc_hold=1 in RUN/REDIR_WAIT
- misalign_trap  out  1  one-cycle pulse on misaligned redirect (trap feature only, else tied 0)

## Operation
- busy = inst_busywait | data_busywait.
- States: BOOT, RUN, REDIR_WAIT; registers: state, pend_target[31:0], stall_count.
- RESET=1 at posedge: state<=BOOT, pend_target<=0, stall_count<=0.
- BOOT: next_pc=RESET_VECTOR, pc_hold=0, if_id_flush=1, id_ex_flush=1; -> RUN unconditionally.
- RUN, priority order:
  - redirect_valid & !busy: next_pc=redirect_target, pc_hold=0, if_id_flush=1, id_ex_flush=1; stay RUN.
  - redirect_valid & busy: pend_target<=redirect_target, pc_hold=1, if_id_hold=1; -> REDIR_WAIT.
  - busy: pc_hold=1, if_id_hold=1, flushes 0.
  - load_use_stall: pc_hold=1, if_id_hold=1, id_ex_flush=1.
  - else: next_pc=pc+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0), pc_hold=0, all controls 0.
- REDIR_WAIT: next_pc=pend_target; if busy: pc_hold=1, if_id_hold=1, stay; else pc_hold=0, if_id_flush=1, id_ex_flush=1, -> RUN. New redirect_valid and load_use_stall ignored here (older instruction already flushed).
- stall_count increments when pc_hold=1 in RUN or REDIR_WAIT, saturates at 16'hFFFF, cleared only by RESET.
- In RUN, next_pc outputs pc+4 whenever no redirect applies, even when held.

## Timing
- All outputs combinational from state, pend_target and current inputs; no added latency. A redirect seen in cycle N with !busy updates PC at posedge N+1 (PC's own write delay applies after).
- Redirect under busy: PC takes pend_target at the first posedge where busy=0; exactly one flush pulse is issued then.
- Reset output values (RESET asserted, combinational override): next_pc=RESET_VECTOR, pc_hold=1, if_id_flush=1, id_ex_flush=1, if_id_hold=0, misalign_trap=0, stall_count=0 from next edge.
- Reset mid-REDIR_WAIT discards pend_target; first post-reset fetch is RESET_VECTOR.
- redirect_valid with load_use_stall in same RUN cycle: redirect wins, no hold.

## Configuration
- PC_MISALIGN_TRAP_EN defined: any applied redirect with target[1:0]!=0 (direct or from pend_target) uses TRAP_VECTOR as next_pc instead and pulses misalign_trap for that cycle; flushes as normal redirect.
- Undefined: target[1:0] ignored, target passed through unchanged; misalign_trap tied 0, TRAP_VECTOR unused.

## Structure
- Shared package: state encoding constants (BOOT=2'd0, RUN=2'd1, REDIR_WAIT=2'd2), default vector constants, PC increment constant 4.
- One sub-module: pc_next_mux (combinational select of pc+4 / redirect_target / pend_target / vectors); FSM and counter stay in top.

## Test plan
- Reset 2 cycles, release, no busy -> cycle after release next_pc=0, pc_hold=0, flushes=1; then pc=0 gives next_pc=4.
- RUN, pc=0x40, redirect_valid=1 target=0x200, busy=0 -> next_pc=0x200, if_id_flush=id_ex_flush=1 for one cycle.
- redirect target=0x300 with inst_busywait=1 for 3 cycles (redirect_valid only first cycle) -> pc_hold=1 three cycles, then next_pc=0x300 with single flush pulse; stall_count=3.
- load_use_stall=1 one cycle, pc=0x80 -> pc_hold=1, if_id_hold=1, id_ex_flush=1; next cycle next_pc=0x84.
- pc=0xFFFF_FFFC, no events -> next_pc=0; 70000 busy cycles -> stall_count=16'hFFFF.
- With PC_MISALIGN_TRAP_EN: redirect target=0x202 -> next_pc=0x100, misalign_trap=1 one cycle; without macro -> next_pc=0x202.

Source files
------------

// File: rtl/pc_fetch_controller_pkg.sv
// Shared constants and types for the PC fetch controller: FSM state encoding,
// boot/trap vectors, PC increment and the next-PC source select.
package pc_fetch_controller_pkg;

   typedef enum logic [1:0] {
      BOOT       = 2'd0,
      RUN        = 2'd1,
      REDIR_WAIT = 2'd2
   } fetch_state_e;

   typedef enum logic [1:0] {
      SEL_SEQ   = 2'd0,
      SEL_REDIR = 2'd1,
      SEL_PEND  = 2'd2,
      SEL_RESET = 2'd3
   } pc_sel_e;

   localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] TRAP_VECTOR  = 32'h0000_0100;
   localparam logic [31:0] PC_INCR      = 32'd4;
   localparam logic [15:0] STALL_MAX    = 16'hFFFF;

   function automatic logic is_misaligned(input logic [31:0] addr);
      return (addr[1:0] != 2'b00);
   endfunction

endpackage

// File: rtl/pc_fetch_controller_if.sv
// Pipeline-side bundle of the fetch controller. master = pipeline/hazard side,
// slave = the controller itself.
interface pc_fetch_controller_if;
   logic [31:0] pc;
   logic        inst_busywait;
   logic        data_busywait;
   logic        load_use_stall;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic [31:0] next_pc;
   logic        pc_hold;
   logic        if_id_hold;
   logic        if_id_flush;
   logic        id_ex_flush;
   logic [15:0] stall_count;
   logic        misalign_trap;

   modport master (
      output pc, inst_busywait, data_busywait, load_use_stall,
             redirect_valid, redirect_target,
      input  next_pc, pc_hold, if_id_hold, if_id_flush, id_ex_flush,
             stall_count, misalign_trap
   );

   modport slave (
      input  pc, inst_busywait, data_busywait, load_use_stall,
             redirect_valid, redirect_target,
      output next_pc, pc_hold, if_id_hold, if_id_flush, id_ex_flush,
             stall_count, misalign_trap
   );
endinterface

// File: rtl/pc_fetch_controller_pc_next_mux.sv
// Next-PC source select: pc+4, live redirect, latched redirect or boot vector.
// With PC_MISALIGN_TRAP_EN defined, misaligned redirect targets map to TRAP_VECTOR.
module pc_next_mux
   import pc_fetch_controller_pkg::*;
(
   input  pc_sel_e     sel,
   input  logic [31:0] pc,
   input  logic [31:0] redirect_target,
   input  logic [31:0] pend_target,
   output logic [31:0] next_pc,
   output logic        trap_hit
);

   // Source select, then optional misaligned-target substitution.
   always_comb begin
      next_pc  = RESET_VECTOR;
      trap_hit = 1'b0;
      case (sel)
         SEL_SEQ:   next_pc = pc + PC_INCR;
         SEL_REDIR: next_pc = redirect_target;
         SEL_PEND:  next_pc = pend_target;
         SEL_RESET: next_pc = RESET_VECTOR;
         default:   next_pc = RESET_VECTOR;
      endcase
`ifdef PC_MISALIGN_TRAP_EN
      if (((sel == SEL_REDIR) || (sel == SEL_PEND)) && is_misaligned(next_pc)) begin
         next_pc  = TRAP_VECTOR;
         trap_hit = 1'b1;
      end else begin
         trap_hit = 1'b0;
      end
`endif
   end

endmodule

// File: rtl/pc_fetch_controller.sv
// PC sequencing and IF/ID, ID/EX hold/flush control; latches redirects that
// arrive under memory busywait. Optional misaligned trap: PC_MISALIGN_TRAP_EN.
module pc_fetch_controller
   import pc_fetch_controller_pkg::*;
(
   input  logic                  CLK,
   input  logic                  RESET,
   pc_fetch_controller_if.slave  bus
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pend_target_q, pend_target_d;
   logic [15:0]  stall_count_q, stall_count_d;

   pc_sel_e      sel;
   logic         busy;
   logic         pc_hold;
   logic         if_id_hold;
   logic         if_id_flush;
   logic         id_ex_flush;
   logic         count_en;
   logic         trap_hit;
   logic [31:0]  mux_next_pc;

   assign busy = bus.inst_busywait | bus.data_busywait;

   // Next-state and pipeline control; RESET overrides everything combinationally.
   always_comb begin
      state_d       = state_q;
      pend_target_d = pend_target_q;
      sel           = SEL_SEQ;
      pc_hold       = 1'b0;
      if_id_hold    = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      count_en      = 1'b0;
      if (RESET) begin
         sel         = SEL_RESET;
         pc_hold     = 1'b1;
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else begin
         case (state_q)
            BOOT: begin
               sel         = SEL_RESET;
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
               state_d     = RUN;
            end
            RUN: begin
               if (bus.redirect_valid && !busy) begin
                  sel         = SEL_REDIR;
                  if_id_flush = 1'b1;
                  id_ex_flush = 1'b1;
               end else if (bus.redirect_valid) begin
                  pend_target_d = bus.redirect_target;
                  pc_hold       = 1'b1;
                  if_id_hold    = 1'b1;
                  count_en      = 1'b1;
                  state_d       = REDIR_WAIT;
               end else if (busy) begin
                  pc_hold    = 1'b1;
                  if_id_hold = 1'b1;
                  count_en   = 1'b1;
               end else if (bus.load_use_stall) begin
                  pc_hold     = 1'b1;
                  if_id_hold  = 1'b1;
                  id_ex_flush = 1'b1;
                  count_en    = 1'b1;
               end else begin
                  sel = SEL_SEQ;
               end
            end
            REDIR_WAIT: begin
               // New redirects/stalls are ignored: the younger instructions die in the flush.
               sel = SEL_PEND;
               if (busy) begin
                  pc_hold    = 1'b1;
                  if_id_hold = 1'b1;
                  count_en   = 1'b1;
               end else begin
                  if_id_flush = 1'b1;
                  id_ex_flush = 1'b1;
                  state_d     = RUN;
               end
            end
            default: begin
               sel         = SEL_RESET;
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
               state_d     = BOOT;
            end
         endcase
      end
   end

   // Saturating count of held cycles.
   always_comb begin
      stall_count_d = stall_count_q;
      if (count_en && (stall_count_q != STALL_MAX)) begin
         stall_count_d = stall_count_q + 16'd1;
      end else begin
         stall_count_d = stall_count_q;
      end
   end

   // State, latched redirect target and stall counter.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q       <= BOOT;
         pend_target_q <= 32'h0000_0000;
         stall_count_q <= 16'd0;
      end else begin
         state_q       <= state_d;
         pend_target_q <= pend_target_d;
         stall_count_q <= stall_count_d;
      end
   end

   pc_next_mux u_pc_next_mux (
      .sel             (sel),
      .pc              (bus.pc),
      .redirect_target (bus.redirect_target),
      .pend_target     (pend_target_q),
      .next_pc         (mux_next_pc),
      .trap_hit        (trap_hit)
   );

   assign bus.next_pc       = mux_next_pc;
   assign bus.pc_hold       = pc_hold;
   assign bus.if_id_hold    = if_id_hold;
   assign bus.if_id_flush   = if_id_flush;
   assign bus.id_ex_flush   = id_ex_flush;
   assign bus.stall_count   = stall_count_q;
   // The trap only fires on the cycle the redirect is actually taken.
   assign bus.misalign_trap = trap_hit & ~pc_hold;

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Self-checking bench for pc_fetch_controller: directed scenarios plus random
// stimulus against a behavioural model. Honours PC_MISALIGN_TRAP_EN.
module tb_pc_fetch_controller;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_pass;

   pc_fetch_controller_if bus ();

   pc_fetch_controller dut (
      .CLK   (clk),
      .RESET (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: "just left reset", "a redirect is waiting", stall tally.
   bit          m_boot;
   bit          m_pend;
   logic [31:0] m_pend_addr;
   int          m_stalls;

   logic [31:0] e_next;
   logic        e_hold, e_ifh, e_iff, e_idf, e_trap;
   logic [31:0] obs_next;
   logic        obs_hold, obs_ifh, obs_iff, obs_idf, obs_trap;
   logic [15:0] obs_stalls;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
   endtask

   function automatic logic [31:0] taken_addr(input logic [31:0] a);
`ifdef PC_MISALIGN_TRAP_EN
      return (a[1:0] != 2'b00) ? 32'h0000_0100 : a;
`else
      return a;
`endif
   endfunction

   function automatic logic taken_trap(input logic [31:0] a);
`ifdef PC_MISALIGN_TRAP_EN
      return (a[1:0] != 2'b00);
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_outputs();
      logic busy;
      busy = bus.inst_busywait | bus.data_busywait;
      e_next = 32'h0; e_hold = 1'b0; e_ifh = 1'b0; e_iff = 1'b0; e_idf = 1'b0; e_trap = 1'b0;
      if (rst) begin
         e_hold = 1'b1; e_iff = 1'b1; e_idf = 1'b1;
      end else if (m_boot) begin
         e_iff = 1'b1; e_idf = 1'b1;
      end else if (m_pend) begin
         e_next = taken_addr(m_pend_addr);
         if (busy) begin
            e_hold = 1'b1; e_ifh = 1'b1;
         end else begin
            e_iff = 1'b1; e_idf = 1'b1; e_trap = taken_trap(m_pend_addr);
         end
      end else if (bus.redirect_valid && !busy) begin
         e_next = taken_addr(bus.redirect_target);
         e_iff = 1'b1; e_idf = 1'b1; e_trap = taken_trap(bus.redirect_target);
      end else begin
         e_next = bus.pc + 32'd4;
         if (busy || bus.redirect_valid) begin
            e_hold = 1'b1; e_ifh = 1'b1;
         end else if (bus.load_use_stall) begin
            e_hold = 1'b1; e_ifh = 1'b1; e_idf = 1'b1;
         end
      end
   endtask

   task automatic model_clock();
      logic busy;
      busy = bus.inst_busywait | bus.data_busywait;
      if (rst) begin
         m_boot = 1'b1; m_pend = 1'b0; m_stalls = 0;
      end else begin
         if (e_hold && m_stalls < 65535) m_stalls++;
         if (m_boot) m_boot = 1'b0;
         else if (m_pend) m_pend = busy;
         else if (bus.redirect_valid && busy) begin
            m_pend = 1'b1; m_pend_addr = bus.redirect_target;
         end
      end
   endtask

   // One clock: drive after negedge, check outputs, clock the model, check counter.
   task automatic step(input logic r, input logic ib, input logic db, input logic lus,
                       input logic rv, input logic [31:0] tgt, input logic [31:0] pcv,
                       input bit full);
      @(negedge clk);
      rst = r;
      bus.inst_busywait = ib; bus.data_busywait = db; bus.load_use_stall = lus;
      bus.redirect_valid = rv; bus.redirect_target = tgt; bus.pc = pcv;
      #1;
      model_outputs();
      obs_next = bus.next_pc; obs_hold = bus.pc_hold; obs_ifh = bus.if_id_hold;
      obs_iff = bus.if_id_flush; obs_idf = bus.id_ex_flush; obs_trap = bus.misalign_trap;
      if (full) begin
         check("next_pc", obs_next, e_next);
         check("pc_hold", {31'd0, obs_hold}, {31'd0, e_hold});
         check("if_id_hold", {31'd0, obs_ifh}, {31'd0, e_ifh});
         check("if_id_flush", {31'd0, obs_iff}, {31'd0, e_iff});
         check("id_ex_flush", {31'd0, obs_idf}, {31'd0, e_idf});
         check("misalign_trap", {31'd0, obs_trap}, {31'd0, e_trap});
      end
      @(posedge clk);
      model_clock();
      #1;
      obs_stalls = bus.stall_count;
      if (full) check("stall_count", {16'd0, obs_stalls}, m_stalls);
   endtask

   initial begin
      logic [31:0] tgt;
      n_checks = 0; n_pass = 0;
      m_boot = 1'b1; m_pend = 1'b0; m_pend_addr = 32'h0; m_stalls = 0;
      rst = 1'b1;
      bus.pc = 32'h0; bus.inst_busywait = 1'b0; bus.data_busywait = 1'b0;
      bus.load_use_stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_target = 32'h0;

      // Reset, boot, first sequential fetch.
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      check("tp_reset_hold", {31'd0, obs_hold}, 32'd1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      check("tp_boot_next", obs_next, 32'h0);
      check("tp_boot_flush", {30'd0, obs_iff, obs_idf}, 32'd3);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      check("tp_seq", obs_next, 32'h4);

      // Direct redirect, with a simultaneous load-use stall that must lose.
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 32'h40, 1'b1);
      check("tp_redir", obs_next, 32'h200);
      check("tp_redir_nohold", {31'd0, obs_hold}, 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h200, 1'b1);

      // Redirect under 3 busy cycles.
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h300, 32'h204, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h999, 32'h204, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h204, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h204, 1'b1);
      check("tp_pend_next", obs_next, 32'h300);
      check("tp_pend_stalls", {16'd0, obs_stalls}, 32'd3);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h300, 1'b1);
      check("tp_single_flush", {31'd0, obs_iff}, 32'd0);

      // Load-use stall then release; PC wrap.
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h80, 1'b1);
      check("tp_lus", {29'd0, obs_hold, obs_ifh, obs_idf}, 32'd7);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h80, 1'b1);
      check("tp_lus_next", obs_next, 32'h84);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFC, 1'b1);
      check("tp_wrap", obs_next, 32'h0);

      // Misaligned redirect target.
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h202, 32'h10, 1'b1);
`ifdef PC_MISALIGN_TRAP_EN
      check("tp_misalign", obs_next, 32'h100);
      check("tp_trap", {31'd0, obs_trap}, 32'd1);
`else
      check("tp_misalign", obs_next, 32'h202);
`endif

      // Reset while a redirect is pending drops it.
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h500, 32'h20, 1'b1);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h20, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h20, 1'b1);
      check("tp_reset_pend", obs_next, 32'h0);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         tgt = $urandom;
         if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
         step(($urandom_range(0, 99) < 2),
              ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 2),
              ($urandom_range(0, 9) < 2), ($urandom_range(0, 9) < 2),
              tgt, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, 1'b1);
      end

      // Counter saturation.
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      for (int i = 0; i < 70000; i++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h8, 1'b0);
      end
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h8, 1'b1);
      check("tp_saturate", {16'd0, obs_stalls}, 32'h0000_FFFF);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
